// File: rtl/vram_dma_pkg.sv
// vram_dma shared definitions
// register map, CTRL bit positions and a byte-lane helper
package vram_dma_pkg;

  localparam int VRAM_ADDR_WIDTH = 12;

  localparam logic [2:0] DMA_REG_SRC_LO = 3'd0;
  localparam logic [2:0] DMA_REG_SRC_HI = 3'd1;
  localparam logic [2:0] DMA_REG_DST_LO = 3'd2;
  localparam logic [2:0] DMA_REG_DST_HI = 3'd3;
  localparam logic [2:0] DMA_REG_LEN_LO = 3'd4;
  localparam logic [2:0] DMA_REG_LEN_HI = 3'd5;
  localparam logic [2:0] DMA_REG_CTRL   = 3'd6;

  localparam int DMA_CTRL_START = 0;
  localparam int DMA_CTRL_ABORT = 1;

  function automatic logic [15:0] put_byte(
    input logic [15:0] w,
    input logic        hi,
    input logic [7:0]  b
  );
    return hi ? {b, w[7:0]} : {w[15:8], b};
  endfunction

endpackage

// File: rtl/vram_dma_regs.sv
// vram_dma config register file
// bytewise SRC/DST/LEN, frozen while a copy runs; CTRL decode
module vram_dma_regs_m
  import vram_dma_pkg::*;
#(
  parameter int VRAM_AW = VRAM_ADDR_WIDTH,
  parameter int SRC_AW  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_i,
  input  logic [2:0]         sel_i,
  input  logic [7:0]         data_i,
  input  logic               busy_i,
  output logic [SRC_AW-1:0]  src_o,
  output logic [VRAM_AW-1:0] dst_o,
  output logic [15:0]        len_o,
  output logic               start_o,
  output logic               abort_o
);

  logic [SRC_AW-1:0]  src_q;
  logic [VRAM_AW-1:0] dst_q;
  logic [15:0]        len_q;
  logic               open_w;
  logic               ctrl_w;

  assign open_w = wr_i && !busy_i;
  assign ctrl_w = wr_i && (sel_i == DMA_REG_CTRL);

  // bits above the register width fall off in the casts
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else if (open_w) begin
      unique case (1'b1)
        sel_i == DMA_REG_SRC_LO:
          src_q <= SRC_AW'(put_byte(16'(src_q), 1'b0, data_i));
        sel_i == DMA_REG_SRC_HI:
          src_q <= SRC_AW'(put_byte(16'(src_q), 1'b1, data_i));
        sel_i == DMA_REG_DST_LO:
          dst_q <= VRAM_AW'(put_byte(16'(dst_q), 1'b0, data_i));
        sel_i == DMA_REG_DST_HI:
          dst_q <= VRAM_AW'(put_byte(16'(dst_q), 1'b1, data_i));
        sel_i == DMA_REG_LEN_LO:
          len_q <= put_byte(len_q, 1'b0, data_i);
        sel_i == DMA_REG_LEN_HI:
          len_q <= put_byte(len_q, 1'b1, data_i);
        default: ;
      endcase
    end
  end

  assign src_o   = src_q;
  assign dst_o   = dst_q;
  assign len_o   = len_q;
  assign abort_o = ctrl_w && data_i[DMA_CTRL_ABORT];
  assign start_o = ctrl_w && data_i[DMA_CTRL_START]
                   && !data_i[DMA_CTRL_ABORT];

endmodule

// File: rtl/vram_dma.sv
// vram_dma: CPU-memory to VRAM block copy gated by the
// GPU write window, with a level-held completion interrupt
module vram_dma
  import vram_dma_pkg::*;
#(
  parameter int VRAM_AW = VRAM_ADDR_WIDTH,
  parameter int SRC_AW  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_write,
  input  logic [2:0]         cfg_sel,
  input  logic [7:0]         cfg_data,
  output logic [SRC_AW-1:0]  src_addr,
  output logic               src_req,
  input  logic               src_ack,
  input  logic [7:0]         src_data,
  input  logic               writable,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_data,
  output logic               vram_we,
  output logic               busy,
  output logic               done_irq,
  input  logic               clr_irq
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [SRC_AW-1:0]  cur_src_q, cur_src_d;
  logic [VRAM_AW-1:0] cur_dst_q, cur_dst_d;
  logic [15:0]        rem_q, rem_d;
  logic [7:0]         byte_q, byte_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SRC_AW-1:0]  reg_src;
  logic [VRAM_AW-1:0] reg_dst;
  logic [15:0]        reg_len;
  logic               start_w;
  logic               abort_w;

  vram_dma_regs_m #(
    .VRAM_AW (VRAM_AW),
    .SRC_AW  (SRC_AW)
  ) u_regs (
    .clk_i   (clk),
    .rst_i   (rst),
    .wr_i    (cfg_write),
    .sel_i   (cfg_sel),
    .data_i  (cfg_data),
    .busy_i  (busy_q),
    .src_o   (reg_src),
    .dst_o   (reg_dst),
    .len_o   (reg_len),
    .start_o (start_w),
    .abort_o (abort_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      rem_q     <= '0;
      byte_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      rem_q     <= rem_d;
      byte_q    <= byte_d;
      req_q     <= req_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (start_w && reg_len != 16'd0) state_d = S_READ;
      S_READ:
        if (src_ack) state_d = writable ? S_WRITE : S_HOLD;
      S_HOLD:
        if (writable) state_d = S_WRITE;
      S_WRITE:
        if (!writable)            state_d = S_HOLD;
        else if (rem_q == 16'd1)  state_d = S_IDLE;
        else                      state_d = S_READ;
      default:
        state_d = S_IDLE;
    endcase
    if (abort_w) state_d = S_IDLE;
  end

  always_comb begin
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    rem_d     = rem_q;
    byte_d    = byte_q;
    done_d    = done_q && !clr_irq;
    case (state_q)
      S_IDLE:
        if (start_w) begin
          cur_src_d = reg_src;
          cur_dst_d = reg_dst;
          rem_d     = reg_len;
          if (reg_len == 16'd0) done_d = 1'b1;
        end
      S_READ:
        if (src_ack) byte_d = src_data;
      S_WRITE:
        if (writable && !abort_w) begin
          cur_src_d = cur_src_q + SRC_AW'(1);
          cur_dst_d = cur_dst_q + VRAM_AW'(1);
          rem_d     = rem_q - 16'd1;
          if (rem_q == 16'd1) done_d = 1'b1;
        end
      default: ;
    endcase
    req_d  = (state_d == S_READ);
    we_d   = (state_d == S_WRITE);
    busy_d = (state_d != S_IDLE);
  end

  // a WRITE entered as the window closes must not strobe VRAM
  assign vram_we   = we_q && writable;
  assign src_addr  = cur_src_q;
  assign src_req   = req_q;
  assign vram_addr = cur_dst_q;
  assign vram_data = byte_q;
  assign busy      = busy_q;
  assign done_irq  = done_q;

endmodule

// File: tb/tb_vram_dma.sv
// tb_vram_dma: randomized and directed checks of vram_dma
// against a byte-list model of the expected reads and writes
module tb_vram_dma;
  import vram_dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_write = 1'b0;
  logic [2:0]  cfg_sel = '0;
  logic [7:0]  cfg_data = '0;
  logic [15:0] src_addr;
  logic        src_req;
  logic        src_ack = 1'b0;
  logic [7:0]  src_data = '0;
  logic        writable = 1'b0;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_we;
  logic        busy;
  logic        done_irq;
  logic        clr_irq = 1'b0;

  always #5 clk = ~clk;

  vram_dma #(.VRAM_AW(12), .SRC_AW(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_write(cfg_write), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .src_addr(src_addr), .src_req(src_req),
    .src_ack(src_ack), .src_data(src_data),
    .writable(writable),
    .vram_addr(vram_addr), .vram_data(vram_data), .vram_we(vram_we),
    .busy(busy), .done_irq(done_irq), .clr_irq(clr_irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0]  smem [0:65535];
  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  int          m_src, m_dst, m_len;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ack_lat = 0;
  bit rand_lat = 1'b0;
  int wait_cnt = 0;

  always @(posedge clk) begin
    #1;
    src_ack  = 1'b0;
    src_data = 8'($urandom);
    if (src_req) begin
      if (wait_cnt >= ack_lat) begin
        src_ack  = 1'b1;
        src_data = smem[src_addr];
        wait_cnt = 0;
        if (rand_lat) ack_lat = $urandom_range(0, 3);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  int  n_wr = 0;
  int  last_we_cyc = -100;
  int  wait_run = 0;
  int  wait_min = 1000;
  int  wait_max = -1;
  bit  prev_hs = 1'b0;
  int  gaps[$];
  wr_t e_m;

  always @(negedge clk) begin
    if (rst) begin
      prev_hs  = 1'b0;
      wait_run = 0;
    end else begin
      if (prev_hs) chk("req_drop", src_req, 0);
      prev_hs = src_req && src_ack;
      if (src_req && src_ack) begin
        chk("rd_expected", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) chk("rd_addr", src_addr, exp_rd.pop_front());
        if (wait_run < wait_min) wait_min = wait_run;
        if (wait_run > wait_max) wait_max = wait_run;
        wait_run = 0;
      end else if (src_req) begin
        wait_run++;
      end else begin
        wait_run = 0;
      end
      if (vram_we) begin
        chk("we_window", writable, 1);
        chk("we_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          e_m = exp_wr.pop_front();
          chk("we_addr", vram_addr, e_m.a);
          chk("we_data", vram_data, e_m.d);
        end
        gaps.push_back(cyc - last_we_cyc);
        last_we_cyc = cyc;
        n_wr++;
      end
    end
  end

  bit wr_rand = 1'b0;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (wr_rand) writable = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic cfg_wr(input logic [2:0] s, input logic [7:0] d);
    cfg_write = 1'b1;
    cfg_sel   = s;
    cfg_data  = d;
    step(1);
    cfg_write = 1'b0;
  endtask

  task automatic set_regs(input int s, input int d, input int l);
    cfg_wr(DMA_REG_SRC_LO, 8'(s));
    cfg_wr(DMA_REG_SRC_HI, 8'(s >> 8));
    cfg_wr(DMA_REG_DST_LO, 8'(d));
    cfg_wr(DMA_REG_DST_HI, 8'(d >> 8));
    cfg_wr(DMA_REG_LEN_LO, 8'(l));
    cfg_wr(DMA_REG_LEN_HI, 8'(l >> 8));
    m_src = s & 32'hFFFF;
    m_dst = d & 32'hFFF;
    m_len = l & 32'hFFFF;
  endtask

  task automatic go();
    for (int k = 0; k < m_len; k++) begin
      exp_wr.push_back('{a: 12'((m_dst + k) % 4096),
                         d: smem[(m_src + k) % 65536]});
      exp_rd.push_back(16'((m_src + k) % 65536));
    end
    cfg_wr(DMA_REG_CTRL, 8'h01);
    if (m_len != 0) begin
      chk("start_req", src_req, 1);
      chk("start_busy", busy, 1);
    end else begin
      chk("zero_busy", busy, 0);
      chk("zero_irq", done_irq, 1);
    end
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (!done_irq && t < budget) begin
      step(1);
      t++;
    end
    chk("done_seen", done_irq, 1);
    if (done_irq) chk("done_lat", cyc - last_we_cyc, 1);
    chk("left_wr", exp_wr.size(), 0);
    chk("busy_end", busy, 0);
  endtask

  task automatic clr();
    clr_irq = 1'b1;
    step(1);
    clr_irq = 1'b0;
    chk("irq_clr", done_irq, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_irq"}, done_irq, 0);
    chk({tag, "_req"}, src_req, 0);
    chk({tag, "_we"}, vram_we, 0);
    chk({tag, "_saddr"}, src_addr, 0);
    chk({tag, "_vaddr"}, vram_addr, 0);
    chk({tag, "_vdata"}, vram_data, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int t;
    int rise;
    for (int i = 0; i < 65536; i++) smem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) smem[16'h1000 + i] = 8'(8'hA0 + i);

    writable = 1'b1;
    rst = 1'b1;
    step(3);
    chk_reset_outs("rst");
    rst = 1'b0;
    step(1);

    // basic copy, same-cycle ack
    gaps.delete();
    n_wr = 0;
    set_regs(16'h1000, 12'h020, 4);
    go();
    wait_done(50);
    chk("basic_n", n_wr, 4);
    for (int i = 1; i < 4; i++) chk("basic_gap", gaps[i], 2);
    clr();

    // window closes after the second byte
    n_wr = 0;
    set_regs(16'h2000, 12'h100, 3);
    go();
    t = 0;
    while (n_wr < 2 && t < 50) begin step(1); t++; end
    chk("gate_reach", n_wr, 2);
    writable = 1'b0;
    step(50);
    chk("gate_hold", n_wr, 2);
    rise = cyc;
    writable = 1'b1;
    wait_done(50);
    chk("gate_lat", last_we_cyc - rise, 1);
    chk("gate_n", n_wr, 3);
    clr();

    // both address counters wrap; DST high bits dropped
    set_regs(16'hFFFF, 16'hFFFF, 2);
    go();
    wait_done(50);
    clr();

    // slow source
    ack_lat  = 5;
    wait_min = 1000;
    wait_max = -1;
    set_regs(16'h3000, 12'h200, 2);
    go();
    wait_done(100);
    chk("slow_min", wait_min, 5);
    chk("slow_max", wait_max, 5);
    ack_lat = 0;
    clr();

    // config writes and a start while busy are ignored
    set_regs(16'h4000, 12'h300, 3);
    go();
    step(1);
    cfg_wr(DMA_REG_SRC_LO, 8'h55);
    cfg_wr(DMA_REG_DST_HI, 8'h07);
    cfg_wr(DMA_REG_CTRL, 8'h01);
    wait_done(50);
    clr();
    go();
    wait_done(50);
    clr();

    // abort mid-copy
    n_wr = 0;
    set_regs(16'h5000, 12'h400, 10);
    go();
    t = 0;
    while (n_wr < 3 && t < 50) begin step(1); t++; end
    chk("abort_reach", n_wr >= 3, 1);
    cfg_wr(DMA_REG_CTRL, 8'h02);
    chk("abort_busy", busy, 0);
    chk("abort_req", src_req, 0);
    chk("abort_we", vram_we, 0);
    exp_wr.delete();
    exp_rd.delete();
    step(20);
    chk("abort_irq", done_irq, 0);
    cfg_wr(DMA_REG_CTRL, 8'h03);
    step(2);
    chk("abort_wins_busy", busy, 0);
    chk("abort_wins_irq", done_irq, 0);

    // zero length with a coincident clear
    n_wr = 0;
    set_regs(16'h6000, 12'h500, 0);
    clr_irq = 1'b1;
    go();
    clr_irq = 1'b0;
    step(5);
    chk("zero_nowr", n_wr, 0);
    chk("zero_hold", done_irq, 1);
    clr();

    // reset during WRITE, then a fresh copy
    set_regs(16'h7000, 12'h600, 6);
    go();
    t = 0;
    while (!vram_we && t < 50) begin step(1); t++; end
    chk("rstw_reach", vram_we, 1);
    rst = 1'b1;
    step(1);
    chk_reset_outs("rstw");
    rst = 1'b0;
    exp_wr.delete();
    exp_rd.delete();
    step(1);
    set_regs(16'h7100, 12'h610, 3);
    go();
    wait_done(50);
    clr();

    // randomized copies with random window and ack latency
    wr_rand  = 1'b1;
    rand_lat = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int s, d, l;
      s = (i % 3 == 0) ? (16'hFFF8 + $urandom_range(0, 7))
                       : $urandom_range(0, 65535);
      d = $urandom_range(0, 65535);
      l = $urandom_range(1, 8);
      set_regs(s, d, l);
      go();
      wait_done(500);
      clr();
    end
    wr_rand  = 1'b0;
    rand_lat = 1'b0;
    ack_lat  = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
